// File: rtl/bit_serializer.sv
// Parallel-to-serial shifter: loads a DATA_W-bit word and emits it one bit per bit_en strobe.
// Latency: first bit on dout one cycle after the accept edge; back-to-back words leave no gap.
// Backpressure: din_ready is high in IDLE or on an advancing last bit; bit_en=0 freezes the frame.
module bit_serializer #(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic              bit_en,
  output logic              dout,
  output logic              dout_valid,
  output logic              dout_last,
  output logic              busy
);

  // Counter holds the number of bits still to come after the one on dout.
  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]        state;
  logic [DATA_W-1:0] sreg;
  logic [CW-1:0]     cnt;
  logic              in_shift;
  logic              cnt_zero;
  logic              last_adv;
  logic              load;
  logic [DATA_W-1:0] sreg_adv;

  assign in_shift = (state == SHIFT);
  assign cnt_zero = (cnt == '0);

  // The last bit is being consumed this cycle, so a new word may take its place.
  assign last_adv  = in_shift && cnt_zero && bit_en;
  assign din_ready = (state == IDLE) || last_adv;
  assign load      = din_valid && din_ready;

  // Next bit moves toward the output end; vacated positions fill with zero.
  assign sreg_adv = MSB_FIRST ? {sreg[DATA_W-2:0], 1'b0}
                              : {1'b0, sreg[DATA_W-1:1]};

  // Frame control: load, advance on strobe, drop back to IDLE after the last bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
    end else if (load) begin
      state <= SHIFT;
      sreg  <= din;
      cnt   <= CW'(DATA_W - 1);
    end else if (in_shift && bit_en) begin
      if (cnt_zero) begin
        state <= IDLE;
        sreg  <= '0;
      end else begin
        sreg <= sreg_adv;
        cnt  <= cnt - CW'(1);
      end
    end
  end

  // Outputs decode straight from state so reset clears them without a clock.
  assign dout       = in_shift ? (MSB_FIRST ? sreg[DATA_W-1] : sreg[0]) : 1'b0;
  assign dout_valid = in_shift;
  assign dout_last  = in_shift && cnt_zero;
  assign busy       = in_shift;

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: MSB-first and LSB-first instances share one stimulus.
// Table-driven per-cycle vectors for the MSB instance, hand sequences for LSB order and reset.
// Inputs change 1 time unit after posedge; outputs are sampled on negedge.
module tb_bit_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] din = '0;
  logic       din_valid = 1'b0;
  logic       bit_en = 1'b0;

  logic m_rdy, m_dout, m_vld, m_last, m_busy;
  logic l_rdy, l_dout, l_vld, l_last, l_busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bit_serializer #(.DATA_W(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(m_rdy),
    .bit_en(bit_en), .dout(m_dout), .dout_valid(m_vld), .dout_last(m_last), .busy(m_busy)
  );

  bit_serializer #(.DATA_W(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(l_rdy),
    .bit_en(bit_en), .dout(l_dout), .dout_valid(l_vld), .dout_last(l_last), .busy(l_busy)
  );

  typedef struct {
    logic       dv;
    logic [7:0] d;
    logic       be;
    logic       e_dout;
    logic       e_vld;
    logic       e_last;
    logic       e_busy;
    logic       e_rdy;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic add(input logic dv, input logic [7:0] d, input logic be,
                     input logic od, input logic ov, input logic ol,
                     input logic ob, input logic orr);
    vec_t v;
    v.dv = dv; v.d = d; v.be = be;
    v.e_dout = od; v.e_vld = ov; v.e_last = ol; v.e_busy = ob; v.e_rdy = orr;
    tbl.push_back(v);
  endtask

  task automatic add_idle(input logic dv, input logic [7:0] d);
    add(dv, d, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [7:0] b;

    // Single word 8'h96, bit_en always high.
    b = 8'h96;
    add_idle(1'b1, 8'h96);
    for (int i = 0; i < 8; i++) add(1'b0, 8'h00, 1'b1, b[7-i], 1'b1, i == 7, 1'b1, i == 7);
    add_idle(1'b0, 8'h00);

    // Back-to-back 8'h90 then 8'h09 with din_valid held.
    add_idle(1'b1, 8'h90);
    b = 8'h90;
    for (int i = 0; i < 8; i++) add(1'b1, 8'h09, 1'b1, b[7-i], 1'b1, i == 7, 1'b1, i == 7);
    b = 8'h09;
    for (int i = 0; i < 8; i++) add(1'b0, 8'h00, 1'b1, b[7-i], 1'b1, i == 7, 1'b1, i == 7);
    add_idle(1'b0, 8'h00);

    // Stall: every bit held over a bit_en=0 cycle then a bit_en=1 cycle.
    add_idle(1'b1, 8'h96);
    b = 8'h96;
    for (int i = 0; i < 8; i++) begin
      add(1'b0, 8'h00, 1'b0, b[7-i], 1'b1, i == 7, 1'b1, 1'b0);
      add(1'b0, 8'h00, 1'b1, b[7-i], 1'b1, i == 7, 1'b1, i == 7);
    end
    add_idle(1'b0, 8'h00);

    // Source offers 8'h55 from counter=5 onward; taken only on the last bit of 8'hA3.
    add_idle(1'b1, 8'hA3);
    b = 8'hA3;
    for (int i = 0; i < 8; i++)
      add(i >= 2, (i >= 2) ? 8'h55 : 8'h00, 1'b1, b[7-i], 1'b1, i == 7, 1'b1, i == 7);
    b = 8'h55;
    for (int i = 0; i < 8; i++) add(1'b0, 8'h00, 1'b1, b[7-i], 1'b1, i == 7, 1'b1, i == 7);
    add_idle(1'b0, 8'h00);

    // Reset: outputs must clear without a clock edge.
    #2 rst = 1'b1;
    #1;
    chk("rst dout", m_dout, 1'b0);
    chk("rst dout_valid", m_vld, 1'b0);
    chk("rst dout_last", m_last, 1'b0);
    chk("rst busy", m_busy, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    foreach (tbl[k]) begin
      din_valid = tbl[k].dv;
      din       = tbl[k].d;
      bit_en    = tbl[k].be;
      @(negedge clk);
      chk($sformatf("vec%0d dout", k),       m_dout, tbl[k].e_dout);
      chk($sformatf("vec%0d dout_valid", k), m_vld,  tbl[k].e_vld);
      chk($sformatf("vec%0d dout_last", k),  m_last, tbl[k].e_last);
      chk($sformatf("vec%0d busy", k),       m_busy, tbl[k].e_busy);
      chk($sformatf("vec%0d din_ready", k),  m_rdy,  tbl[k].e_rdy);
      @(posedge clk);
      #1;
    end

    // LSB-first instance: 8'h09 -> 1,0,0,1,0,0,0,0.
    b = 8'h09;
    din = 8'h09; din_valid = 1'b1; bit_en = 1'b1;
    @(negedge clk);
    chk("lsb accept ready", l_rdy, 1'b1);
    @(posedge clk);
    #1 din_valid = 1'b0; din = 8'h00;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("lsb bit%0d dout", i), l_dout, b[i]);
      chk($sformatf("lsb bit%0d valid", i), l_vld, 1'b1);
      chk($sformatf("lsb bit%0d last", i), l_last, i == 7);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("lsb idle dout", l_dout, 1'b0);
    chk("lsb idle valid", l_vld, 1'b0);
    @(posedge clk);
    #1;

    // Reset mid-frame after the third bit of 8'hFF.
    din = 8'hFF; din_valid = 1'b1; bit_en = 1'b1;
    @(posedge clk);
    #1 din_valid = 1'b0; din = 8'h00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("midrst bit%0d dout", i), m_dout, 1'b1);
      @(posedge clk);
      #1;
    end
    chk("midrst busy before", m_busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("midrst async dout", m_dout, 1'b0);
    chk("midrst async valid", m_vld, 1'b0);
    chk("midrst async busy", m_busy, 1'b0);
    chk("midrst async lsb busy", l_busy, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post rst din_ready", m_rdy, 1'b1);
    chk("post rst dout", m_dout, 1'b0);
    chk("post rst valid", m_vld, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      chk($sformatf("post rst c%0d dout", i), m_dout, 1'b0);
      chk($sformatf("post rst c%0d valid", i), m_vld, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, width of each parallel word (legal range 2..32).
REQ-002 SHALL have parameter MSB_FIRST, default 1: 1 = bit DATA_W-1 is sent first, 0 = bit 0 is sent first.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port din  input  DATA_W  parallel word to serialize.
REQ-006 SHALL have port din_valid  input  1  din holds a word for transfer.
REQ-007 SHALL have port din_ready  output  1  block accepts din this cycle.
REQ-008 SHALL have port bit_en  input  1  shift strobe; one serial bit advances per cycle with bit_en=1.
REQ-009 SHALL have port dout  output  1  serial bit to the downstream sequence detector data input.
REQ-010 SHALL have port dout_valid  output  1  dout carries a frame bit.
REQ-011 SHALL have port dout_last  output  1  dout carries the final bit of the current word.
REQ-012 SHALL have port busy  output  1  a word is being shifted out.

Function
REQ-013 SHALL implement two states: IDLE and SHIFT.
REQ-014 SHALL transfer a word on the rising edge where din_valid=1 and din_ready=1; no transfer otherwise.
REQ-015 SHALL drive din_ready = (state==IDLE) OR (state==SHIFT AND bit counter==0 AND bit_en==1), combinationally.
REQ-016 On transfer from IDLE: next state SHIFT, word loaded into shift register, bit counter = DATA_W-1, dout = first bit, dout_valid=1, busy=1; latency is 1 cycle from accept edge to first bit.
REQ-017 In SHIFT with bit_en=1 and counter>0: shift register advances one position toward the output end, counter decrements by 1, dout = next bit.
REQ-018 In SHIFT with bit_en=0: dout, dout_valid, dout_last, counter and shift register SHALL hold unchanged.
REQ-019 dout_last SHALL be 1 exactly while counter==0 in SHIFT; 0 otherwise.
REQ-020 In SHIFT with counter==0 and bit_en=1: if din_valid=1, load the new word as in REQ-016 (back-to-back, no idle bit); else return to IDLE.
REQ-021 In IDLE: dout=0, dout_valid=0, dout_last=0, busy=0; bit_en is ignored.
REQ-022 din_valid asserted in SHIFT while counter>0 SHALL be ignored (din_ready=0); the source holds the word, so the block loses none.
REQ-023 Every accepted word SHALL produce exactly DATA_W bits with dout_valid=1 on bit_en=1 cycles, in the order set by MSB_FIRST.
REQ-024 Bit counter SHALL be sized ceil(log2(DATA_W)) bits and never wrap below 0.

Reset
REQ-025 While rst=1: state=IDLE, shift register=0, counter=0, dout=0, dout_valid=0, dout_last=0, busy=0, all immediately without waiting for clk.
REQ-026 Reset asserted mid-frame SHALL abandon the word; no remaining bits appear after rst deasserts.
REQ-027 din_ready SHALL be 1 on the first cycle after rst deasserts.

Verification
REQ-028 MSB_FIRST=1, DATA_W=8, bit_en=1: accept 8'h96 -> dout 1,0,0,1,0,1,1,0 on the 8 cycles after accept; dout_last only on the 8th; then IDLE with dout=0.
REQ-029 Back-to-back: 8'h90 then 8'h09 with din_valid held -> 16 contiguous bits 1001000000001001; din_ready high only in IDLE and on the 8th bit cycle; busy never drops.
REQ-030 Stall: bit_en pattern 1,0,1,0,... with 8'h96 -> each bit held 2 cycles, 16 cycles total, order unchanged.
REQ-031 MSB_FIRST=0: accept 8'h09 -> dout 1,0,0,1,0,0,0,0.
REQ-032 Reset mid-frame: rst=1 after 3rd bit of 8'hFF -> dout, dout_valid, busy go to 0 asynchronously; after release dout stays 0 and din_ready=1.
REQ-033 Busy source: din_valid=1 with 8'h55 while counter=5 -> din_ready=0, no load; word accepted on the last-bit cycle and shifted next.
